// File: rtl/uart_frame_decoder.sv
// uart_frame_decoder
// Sits behind uart_rx and parses framed packets of the form
// SYNC, CMD, LEN, LEN payload bytes, CHK. The payload is buffered, the
// checksum is verified, and a good payload is then streamed out over a
// valid/ready handshake. Errors are reported as single-cycle pulses.
//
// Ports:
//   clk, rst            system clock, synchronous active-high reset
//   rx_data, rx_valid   received byte and its one-cycle strobe
//   out_data, out_valid payload byte stream (held while !out_ready)
//   out_ready, out_last consumer accept, marks the final payload byte
//   frame_cmd/len       CMD and LEN of the last validated frame
//   frame_ok, frame_err one-cycle validated / discarded pulses
//   err_code            1=LEN too large, 2=checksum, 3=timeout (with frame_err)
//   overrun             one-cycle pulse, byte dropped while draining
module uart_frame_decoder #(
  parameter int         CLK_FREQ       = 12_000_000,
  parameter int         BAUDRATE       = 230_400,
  parameter int         MAX_LEN        = 16,
  parameter logic [7:0] SYNC_BYTE      = 8'hA5,
  parameter int         TIMEOUT_CYCLES = (CLK_FREQ / BAUDRATE) * 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       out_last,
  output logic [7:0] frame_cmd,
  output logic [7:0] frame_len,
  output logic       frame_ok,
  output logic       frame_err,
  output logic [1:0] err_code,
  output logic       overrun
);

  localparam int              TO_W      = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TO_W-1:0] TO_LAST   = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [TO_W-1:0] TO_ONE    = TO_W'(1);
  localparam logic [7:0]      MAX_LEN_B = 8'(MAX_LEN);
  localparam int              IDX_W     = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CMD     = 3'd1,
    S_LEN     = 3'd2,
    S_PAYLOAD = 3'd3,
    S_CHK     = 3'd4,
    S_DRAIN   = 3'd5
  } state_t;

  // Running 8-bit checksum accumulation (mod 256).
  function automatic logic [7:0] csum_add(input logic [7:0] acc, input logic [7:0] b);
    return acc + b;
  endfunction

  state_t          state_r, state_nxt_s;
  logic [7:0]      sum_r, cmd_r, len_r, wr_idx_r, rd_idx_r;
  logic [TO_W-1:0] to_cnt_r;
  logic [7:0]      payload_mem [MAX_LEN];

  logic       in_frame_s, expire_s, hs_s, good_sum_s, last_pay_s;
  logic       ok_s, err_s;
  logic [1:0] err_code_s;
  logic [7:0] rd_nxt_s;

  assign in_frame_s = (state_r == S_CMD) || (state_r == S_LEN) ||
                      (state_r == S_PAYLOAD) || (state_r == S_CHK);
  // An arriving byte always beats a coincident expiry.
  assign expire_s   = in_frame_s && !rx_valid && (to_cnt_r == TO_LAST);
  assign hs_s       = (state_r == S_DRAIN) && out_valid && out_ready;
  assign good_sum_s = (csum_add(sum_r, rx_data) == 8'h00);
  assign last_pay_s = (wr_idx_r == (len_r - 8'd1));
  assign rd_nxt_s   = rd_idx_r + 8'd1;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state and pulse decode.
  always_comb begin
    state_nxt_s = state_r;
    ok_s        = 1'b0;
    err_s       = 1'b0;
    err_code_s  = 2'd0;
    case (state_r)
      S_IDLE: begin
        if (rx_valid && (rx_data == SYNC_BYTE)) state_nxt_s = S_CMD;
        else                                    state_nxt_s = S_IDLE;
      end
      S_CMD: begin
        if (rx_valid) begin
          state_nxt_s = S_LEN;
        end else if (expire_s) begin
          state_nxt_s = S_IDLE; err_s = 1'b1; err_code_s = 2'd3;
        end else begin
          state_nxt_s = S_CMD;
        end
      end
      S_LEN: begin
        if (rx_valid) begin
          if (rx_data > MAX_LEN_B) begin
            state_nxt_s = S_IDLE; err_s = 1'b1; err_code_s = 2'd1;
          end else if (rx_data == 8'd0) begin
            state_nxt_s = S_CHK;
          end else begin
            state_nxt_s = S_PAYLOAD;
          end
        end else if (expire_s) begin
          state_nxt_s = S_IDLE; err_s = 1'b1; err_code_s = 2'd3;
        end else begin
          state_nxt_s = S_LEN;
        end
      end
      S_PAYLOAD: begin
        if (rx_valid) begin
          if (last_pay_s) state_nxt_s = S_CHK;
          else            state_nxt_s = S_PAYLOAD;
        end else if (expire_s) begin
          state_nxt_s = S_IDLE; err_s = 1'b1; err_code_s = 2'd3;
        end else begin
          state_nxt_s = S_PAYLOAD;
        end
      end
      S_CHK: begin
        if (rx_valid) begin
          if (good_sum_s) begin
            ok_s = 1'b1;
            if (len_r == 8'd0) state_nxt_s = S_IDLE;
            else               state_nxt_s = S_DRAIN;
          end else begin
            state_nxt_s = S_IDLE; err_s = 1'b1; err_code_s = 2'd2;
          end
        end else if (expire_s) begin
          state_nxt_s = S_IDLE; err_s = 1'b1; err_code_s = 2'd3;
        end else begin
          state_nxt_s = S_CHK;
        end
      end
      S_DRAIN: begin
        if (hs_s && out_last) state_nxt_s = S_IDLE;
        else                  state_nxt_s = S_DRAIN;
      end
      default: begin
        state_nxt_s = S_IDLE;
      end
    endcase
  end

  // Payload buffer write port; contents need no reset.
  always_ff @(posedge clk) begin
    if (rx_valid && (state_r == S_PAYLOAD)) begin
      payload_mem[wr_idx_r[IDX_W-1:0]] <= rx_data;
    end
  end

  // Datapath: checksum, indices, timeout counter and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_data  <= 8'd0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      frame_cmd <= 8'd0;
      frame_len <= 8'd0;
      frame_ok  <= 1'b0;
      frame_err <= 1'b0;
      err_code  <= 2'd0;
      overrun   <= 1'b0;
      sum_r     <= 8'd0;
      cmd_r     <= 8'd0;
      len_r     <= 8'd0;
      wr_idx_r  <= 8'd0;
      rd_idx_r  <= 8'd0;
      to_cnt_r  <= '0;
    end else begin
      frame_ok  <= ok_s;
      frame_err <= err_s;
      err_code  <= err_code_s;
      overrun   <= (state_r == S_DRAIN) && rx_valid;

      if (in_frame_s && !rx_valid && !expire_s) to_cnt_r <= to_cnt_r + TO_ONE;
      else                                     to_cnt_r <= '0;

      if (rx_valid) begin
        case (state_r)
          S_IDLE:    sum_r <= 8'd0;
          S_CMD:     begin cmd_r <= rx_data; sum_r <= csum_add(8'd0, rx_data); end
          S_LEN:     begin len_r <= rx_data; wr_idx_r <= 8'd0; sum_r <= csum_add(sum_r, rx_data); end
          S_PAYLOAD: begin wr_idx_r <= wr_idx_r + 8'd1; sum_r <= csum_add(sum_r, rx_data); end
          default:   sum_r <= sum_r;
        endcase
      end

      if (ok_s) begin
        frame_cmd <= cmd_r;
        frame_len <= len_r;
      end

      // First payload byte is presented together with frame_ok.
      if (ok_s && (len_r != 8'd0)) begin
        out_valid <= 1'b1;
        out_data  <= payload_mem[0];
        out_last  <= (len_r == 8'd1);
        rd_idx_r  <= 8'd0;
      end else if (hs_s) begin
        if (out_last) begin
          out_valid <= 1'b0;
          out_last  <= 1'b0;
        end else begin
          rd_idx_r  <= rd_nxt_s;
          out_data  <= payload_mem[rd_nxt_s[IDX_W-1:0]];
          out_last  <= (rd_nxt_s == (len_r - 8'd1));
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_frame_decoder.sv
module tb_uart_frame_decoder;

  localparam int         MAX_LEN = 16;
  localparam int         TIMEOUT = 1040;   // (12e6/230400 = 52) * 20
  localparam logic [7:0] SYNC    = 8'hA5;

  logic       clk       = 1'b0;
  logic       rst       = 1'b1;
  logic [7:0] rx_data   = 8'h00;
  logic       rx_valid  = 1'b0;
  logic       out_ready = 1'b0;
  logic [7:0] out_data, frame_cmd, frame_len;
  logic       out_valid, out_last, frame_ok, frame_err, overrun;
  logic [1:0] err_code;

  uart_frame_decoder dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last), .frame_cmd(frame_cmd), .frame_len(frame_len),
    .frame_ok(frame_ok), .frame_err(frame_err), .err_code(err_code),
    .overrun(overrun)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int hs_cnt   = 0;
  int to_count = 0;
  bit rand_ready = 1'b0;

  // Frame-level reference: bytes of the frame being collected, bytes still to drain.
  logic [7:0] fq [$];
  logic [7:0] dq [$];
  bit         collecting = 1'b0;
  int         idle = 0;
  int         msum = 0;
  logic       exp_ok = 1'b0, exp_err = 1'b0, exp_ovr = 1'b0;
  logic [1:0] exp_code = 2'd0;
  logic [7:0] exp_cmd = 8'd0, exp_len = 8'd0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    if (!rst && out_valid === 1'b1 && out_ready) hs_cnt++;
    if (rst) begin
      fq.delete(); dq.delete(); collecting = 1'b0; idle = 0;
      exp_ok = 1'b0; exp_err = 1'b0; exp_ovr = 1'b0; exp_code = 2'd0;
      exp_cmd = 8'd0; exp_len = 8'd0;
    end else begin
      exp_ok = 1'b0; exp_err = 1'b0; exp_ovr = 1'b0; exp_code = 2'd0;
      if (dq.size() != 0) begin
        if (rx_valid) exp_ovr = 1'b1;
        if (out_ready) void'(dq.pop_front());
      end else if (!collecting) begin
        if (rx_valid && rx_data == SYNC) begin
          collecting = 1'b1; fq.delete(); idle = 0;
        end
      end else if (rx_valid) begin
        idle = 0;
        fq.push_back(rx_data);
        if (fq.size() == 2 && int'(fq[1]) > MAX_LEN) begin
          exp_err = 1'b1; exp_code = 2'd1; collecting = 1'b0;
        end else if (fq.size() >= 2 && fq.size() == int'(fq[1]) + 3) begin
          msum = 0;
          foreach (fq[i]) msum += int'(fq[i]);
          if (msum % 256 == 0) begin
            exp_ok = 1'b1; exp_cmd = fq[0]; exp_len = fq[1];
            for (int i = 2; i < fq.size() - 1; i++) dq.push_back(fq[i]);
          end else begin
            exp_err = 1'b1; exp_code = 2'd2;
          end
          collecting = 1'b0;
        end
      end else begin
        idle++;
        if (idle == TIMEOUT) begin
          exp_err = 1'b1; exp_code = 2'd3; collecting = 1'b0;
        end
      end
    end
  endtask

  task automatic compare_step();
    check("out_valid", out_valid, dq.size() != 0);
    if (dq.size() != 0) begin
      check("out_data", out_data, dq[0]);
      check("out_last", out_last, dq.size() == 1);
    end
    check("frame_ok", frame_ok, exp_ok);
    check("frame_err", frame_err, exp_err);
    check("err_code", err_code, exp_code);
    check("overrun", overrun, exp_ovr);
    check("frame_cmd", frame_cmd, exp_cmd);
    check("frame_len", frame_len, exp_len);
  endtask

  always @(posedge clk) model_step();
  always @(negedge clk) compare_step();

  task automatic tick();
    @(negedge clk);
    if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic send_gap(input logic [7:0] b, input int gap);
    repeat (gap) tick();
    send_byte(b);
  endtask

  task automatic wait_drain();
    int n = 0;
    while (out_valid === 1'b1 && n < 300) begin
      tick();
      n++;
    end
    check("drain_bound", out_valid, 1'b0);
  endtask

  logic [7:0] fr [$];
  logic [7:0] cmdv, lenv, bv;
  int         kind, fsum, hs0;

  initial begin
    repeat (3) tick();
    rst = 1'b0;
    tick();

    // Good frame at UART byte pacing.
    out_ready = 1'b1;
    send_gap(8'hA5, 2); send_gap(8'h01, 519); send_gap(8'h02, 519);
    send_gap(8'h10, 519); send_gap(8'h20, 519); send_gap(8'hCD, 519);
    check("t1_ok", frame_ok, 1'b1);
    check("t1_cmd", frame_cmd, 8'h01);
    check("t1_len", frame_len, 8'h02);
    check("t1_d0", out_data, 8'h10);
    check("t1_v0", out_valid, 1'b1);
    check("t1_l0", out_last, 1'b0);
    tick();
    check("t1_d1", out_data, 8'h20);
    check("t1_l1", out_last, 1'b1);
    tick();
    check("t1_end", out_valid, 1'b0);

    // Backpressure.
    out_ready = 1'b0;
    send_gap(8'hA5, 2); send_gap(8'h01, 1); send_gap(8'h02, 1);
    send_gap(8'h10, 1); send_gap(8'h20, 1); send_gap(8'hCD, 1);
    hs0 = hs_cnt;
    check("t2_v", out_valid, 1'b1);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("t2_hold_v", out_valid, 1'b1);
      check("t2_hold_d", out_data, 8'h10);
    end
    for (int i = 0; i < 20; i++) begin
      out_ready = ~out_ready;
      tick();
    end
    check("t2_hs", hs_cnt - hs0, 2);
    check("t2_end", out_valid, 1'b0);
    out_ready = 1'b1;

    // Checksum error.
    send_gap(8'hA5, 2); send_gap(8'h01, 1); send_gap(8'h02, 1);
    send_gap(8'h10, 1); send_gap(8'h20, 1); send_gap(8'hCC, 1);
    check("t3_err", frame_err, 1'b1);
    check("t3_code", err_code, 2'd2);
    check("t3_v", out_valid, 1'b0);
    tick();
    check("t3_pulse", frame_err, 1'b0);

    // Length error, then a zero-length frame.
    send_gap(8'hA5, 2); send_gap(8'h07, 1); send_gap(8'h11, 1);
    check("t4_err", frame_err, 1'b1);
    check("t4_code", err_code, 2'd1);
    send_gap(8'hA5, 2); send_gap(8'h01, 1); send_gap(8'h00, 1); send_gap(8'hFF, 1);
    check("t4_ok", frame_ok, 1'b1);
    check("t4_len", frame_len, 8'h00);
    check("t4_v", out_valid, 1'b0);

    // Timeout after CMD, then noise, then a frame.
    send_gap(8'hA5, 2); send_gap(8'h01, 1);
    for (int k = 1; k <= TIMEOUT; k++) begin
      tick();
      if (k < TIMEOUT) begin
        check("t5_early", frame_err, 1'b0);
      end else begin
        check("t5_err", frame_err, 1'b1);
        check("t5_code", err_code, 2'd3);
      end
    end
    send_gap(8'h00, 3); send_gap(8'h3C, 3);
    send_gap(8'hA5, 3); send_gap(8'h03, 1); send_gap(8'h00, 1); send_gap(8'hFD, 1);
    check("t5_ok", frame_ok, 1'b1);
    check("t5_cmd", frame_cmd, 8'h03);

    // Overrun during a stalled drain.
    out_ready = 1'b0;
    send_gap(8'hA5, 2); send_gap(8'h01, 1); send_gap(8'h02, 1);
    send_gap(8'h10, 1); send_gap(8'h20, 1); send_gap(8'hCD, 1);
    send_gap(8'h77, 1);
    check("t6_ovr", overrun, 1'b1);
    check("t6_d0", out_data, 8'h10);
    tick();
    check("t6_ovr_pulse", overrun, 1'b0);
    out_ready = 1'b1;
    tick();
    check("t6_d1", out_data, 8'h20);
    tick();
    check("t6_end", out_valid, 1'b0);

    // Reset in the middle of a payload.
    send_gap(8'hA5, 2); send_gap(8'h01, 1); send_gap(8'h03, 1);
    send_gap(8'h11, 1); send_gap(8'h22, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t7_cmd", frame_cmd, 8'h00);
    check("t7_len", frame_len, 8'h00);
    check("t7_v", out_valid, 1'b0);
    check("t7_err", frame_err, 1'b0);
    repeat (3) tick();
    send_gap(8'h33, 1);
    send_gap(8'hA5, 2); send_gap(8'h02, 1); send_gap(8'h01, 1);
    send_gap(8'h55, 1); send_gap(8'hA8, 1);
    check("t7_ok", frame_ok, 1'b1);
    check("t7_d", out_data, 8'h55);
    check("t7_last", out_last, 1'b1);
    tick();

    // Randomized traffic checked by the reference.
    rand_ready = 1'b1;
    for (int f = 0; f < 80; f++) begin
      fr.delete();
      kind = $urandom_range(0, 9);
      if (kind <= 6) begin
        cmdv = 8'($urandom);
        lenv = 8'($urandom_range(0, MAX_LEN));
        fr.push_back(SYNC); fr.push_back(cmdv); fr.push_back(lenv);
        fsum = int'(cmdv) + int'(lenv);
        for (int i = 0; i < int'(lenv); i++) begin
          bv = 8'($urandom);
          fr.push_back(bv);
          fsum += int'(bv);
        end
        bv = 8'((256 - (fsum % 256)) % 256);
        if (kind == 6) bv = bv + 8'($urandom_range(1, 255));
        fr.push_back(bv);
      end else if (kind == 7) begin
        fr.push_back(SYNC); fr.push_back(8'($urandom));
        fr.push_back(8'($urandom_range(MAX_LEN + 1, 255)));
      end else if (kind == 9 && to_count < 2) begin
        wait_drain();
        fr.push_back(SYNC); fr.push_back(8'($urandom)); fr.push_back(8'h05);
        fr.push_back(8'($urandom));
        to_count++;
      end else begin
        for (int i = 0; i < int'($urandom_range(1, 4)); i++) begin
          bv = 8'($urandom);
          if (bv == SYNC) bv = 8'h5A;
          fr.push_back(bv);
        end
      end
      foreach (fr[i]) send_gap(fr[i], $urandom_range(0, 4));
      if (kind == 9) repeat (TIMEOUT + 4) tick();
      if ($urandom_range(0, 4) != 0) wait_drain();
    end

    rand_ready = 1'b0;
    out_ready  = 1'b1;
    wait_drain();
    repeat (10) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
